// File: rtl/i2c_apb_arbiter_if.sv
// i2c_apb_arbiter_if: signal bundle between requesters, the arbiter and the I2C master command port
// master: arbiter view (takes requests and master responses, drives acks and the command strobe)
// slave:  environment view (requesters plus I2C master)
interface i2c_apb_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req, req_wr, req_ack;
  logic [8*N_REQ-1:0] req_addr, req_wdata;
  logic req_err, busy, to_flag, to_clr;
  logic [7:0] req_rdata;
  logic m_ce, m_wren, m_rden, m_ready, m_error;
  logic [7:0] m_addr, m_wdata, m_rdata;
  modport master (
    input  req, req_wr, req_addr, req_wdata, to_clr, m_rdata, m_ready, m_error,
    output req_ack, req_err, req_rdata, busy, to_flag, m_ce, m_wren, m_rden, m_addr, m_wdata
  );
  modport slave (
    output req, req_wr, req_addr, req_wdata, to_clr, m_rdata, m_ready, m_error,
    input  req_ack, req_err, req_rdata, busy, to_flag, m_ce, m_wren, m_rden, m_addr, m_wdata
  );
endinterface

// File: rtl/i2c_apb_arbiter.sv
// i2c_apb_arbiter: round-robin sharing of one I2C master command port among N_REQ requesters
// clk/reset: single clock, async active-high reset
// bus.req*: per-requester request level, direction, address, write data
// bus.req_ack/req_err/req_rdata: completion pulse to the granted requester with its result
// bus.busy/to_flag/to_clr: activity, sticky timeout flag and its clear
// bus.m_*: command strobe out to the I2C master and its completion/error/read data back
module i2c_apb_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096
) (
  input logic clk,
  input logic reset,
  i2c_apb_arbiter_if.master bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, win;
  logic wr_q, wr_d, err_q, err_d, to_q, to_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [TW-1:0] timer_q, timer_d;
  // Scan downward so the lowest offset from ptr (highest priority) is written last
  always_comb begin
    win = ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (bus.req[(int'(ptr_q) + k) % N_REQ]) win = IW'((int'(ptr_q) + k) % N_REQ);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      to_q    <= to_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      timer_q <= timer_d;
    end
  // A timeout setting to_flag overrides a simultaneous clear
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    err_d   = err_q;
    to_d    = to_q & ~bus.to_clr;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d = ISSUE;
        idx_d   = win;
        ptr_d   = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
        wr_d    = bus.req_wr[win];
        addr_d  = bus.req_addr[{win, 3'b000} +: 8];
        wdata_d = bus.req_wdata[{win, 3'b000} +: 8];
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: if (bus.m_ready) begin
        state_d = DONE;
        err_d   = bus.m_error;
        rdata_d = wr_q ? rdata_q : bus.m_rdata;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        state_d = DONE;
        err_d   = 1'b1;
        to_d    = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs decode registers only, so nothing from req or m_* reaches them combinationally
  always_comb begin
    bus.m_ce      = state_q == ISSUE;
    bus.m_wren    = (state_q == ISSUE) & wr_q;
    bus.m_rden    = (state_q == ISSUE) & ~wr_q;
    bus.m_addr    = addr_q;
    bus.m_wdata   = wdata_q;
    bus.busy      = state_q != IDLE;
    bus.req_ack   = (state_q == DONE) ? N_REQ'(1) << idx_q : '0;
    bus.req_err   = (state_q == DONE) & err_q;
    bus.req_rdata = rdata_q;
    bus.to_flag   = to_q;
  end
endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// tb_i2c_apb_arbiter: scenario tasks against a transaction-level model of the arbiter
module tb_i2c_apb_arbiter;
  localparam int N = 4, TO = 8;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  i2c_apb_arbiter_if #(.N_REQ(N)) bus();
  i2c_apb_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, failures = 0, mptr = 0;
  logic [7:0] mrd = 8'h00;
  logic mto = 1'b0;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    bus.req = '0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mptr = 0;
    mrd = 8'h00;
    mto = 1'b0;
  endtask
  // One transaction from IDLE back to IDLE; dly >= TO means the master never answers
  task automatic service(input int dly, input logic merr, input logic [7:0] rdv,
                         input logic scramble, input logic clr_last, output int w);
    logic wr, tmo;
    logic [7:0] a, d;
    logic [N-1:0] ea;
    int n;
    w = -1;
    for (int k = 0; k < N; k++) if (w < 0 && bus.req[(mptr + k) % N]) w = (mptr + k) % N;
    wr = bus.req_wr[w];
    a = bus.req_addr[8*w +: 8];
    d = bus.req_wdata[8*w +: 8];
    mptr = (w + 1) % N;
    tmo = dly >= TO;
    n = tmo ? TO : dly + 1;
    ea = '0;
    ea[w] = 1'b1;
    cyc();
    checks++;
    if (bus.m_ce !== 1'b1 || bus.m_wren !== wr || bus.m_rden !== ~wr || bus.m_addr !== a ||
        bus.m_wdata !== d || bus.busy !== 1'b1 || bus.req_ack !== '0) begin
      failures++;
      $display("FAIL issue: ce=%b wren=%b rden=%b addr=%h wdata=%h busy=%b ack=%b want wr=%b addr=%h wdata=%h",
               bus.m_ce, bus.m_wren, bus.m_rden, bus.m_addr, bus.m_wdata, bus.busy, bus.req_ack, wr, a, d);
    end
    if (scramble) begin
      bus.req_addr = 32'($urandom);
      bus.req_wdata = 32'($urandom);
      bus.req_wr = 4'($urandom);
      bus.req[w] = 1'b0;
      bus.m_ready = 1'b1;
      bus.m_error = 1'b1;
    end
    cyc();
    bus.m_ready = 1'b0;
    bus.m_error = 1'b0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bus.m_ce !== 1'b0 || bus.m_wren !== 1'b0 || bus.m_rden !== 1'b0 || bus.m_addr !== a ||
          bus.m_wdata !== d || bus.busy !== 1'b1 || bus.req_ack !== '0) begin
        failures++;
        $display("FAIL wait%0d: ce=%b wren=%b rden=%b addr=%h wdata=%h busy=%b ack=%b want addr=%h wdata=%h",
                 i, bus.m_ce, bus.m_wren, bus.m_rden, bus.m_addr, bus.m_wdata, bus.busy, bus.req_ack, a, d);
      end
      bus.m_rdata = 8'($urandom);
      if (!tmo && i == dly) begin
        bus.m_ready = 1'b1;
        bus.m_error = merr;
        bus.m_rdata = rdv;
      end
      if (tmo && i == n - 1 && clr_last) bus.to_clr = 1'b1;
      cyc();
      bus.m_ready = 1'b0;
      bus.m_error = 1'b0;
      bus.to_clr = 1'b0;
    end
    if (tmo) mto = 1'b1;
    else if (!wr) mrd = rdv;
    checks++;
    if (bus.req_ack !== ea || bus.req_err !== (tmo | merr) || bus.req_rdata !== mrd ||
        bus.to_flag !== mto || bus.busy !== 1'b1 || bus.m_ce !== 1'b0) begin
      failures++;
      $display("FAIL done: ack=%b err=%b rdata=%h to=%b busy=%b want ack=%b err=%b rdata=%h to=%b",
               bus.req_ack, bus.req_err, bus.req_rdata, bus.to_flag, bus.busy, ea, tmo | merr, mrd, mto);
    end
    cyc();
    checks++;
    if (bus.req_ack !== '0 || bus.busy !== 1'b0 || bus.req_err !== 1'b0) begin
      failures++;
      $display("FAIL idle: ack=%b busy=%b err=%b want 0", bus.req_ack, bus.busy, bus.req_err);
    end
  endtask
  task automatic check_zero(input string tag);
    checks++;
    if (bus.req_ack !== '0 || bus.req_err !== 1'b0 || bus.req_rdata !== 8'h00 || bus.busy !== 1'b0 ||
        bus.to_flag !== 1'b0 || bus.m_ce !== 1'b0 || bus.m_wren !== 1'b0 || bus.m_rden !== 1'b0 ||
        bus.m_addr !== 8'h00 || bus.m_wdata !== 8'h00) begin
      failures++;
      $display("FAIL %s: ack=%b err=%b rdata=%h busy=%b to=%b ce=%b wren=%b rden=%b addr=%h wdata=%h want all 0",
               tag, bus.req_ack, bus.req_err, bus.req_rdata, bus.busy, bus.to_flag, bus.m_ce, bus.m_wren,
               bus.m_rden, bus.m_addr, bus.m_wdata);
    end
  endtask
  task automatic check_grant(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: grant=%0d want %0d", tag, got, want);
    end
  endtask
  task automatic test_reset();
    cyc();
    cyc();
    check_zero("reset");
    reset = 1'b0;
  endtask
  task automatic test_single_read();
    int w;
    bus.req = 4'b0001;
    bus.req_wr = 4'b0000;
    bus.req_addr[7:0] = 8'h12;
    service(0, 1'b0, 8'hA5, 1'b0, 1'b0, w);
    check_grant("single_read", w, 0);
    bus.req = '0;
  endtask
  task automatic test_write_error();
    int w;
    bus.req = 4'b0010;
    bus.req_wr = 4'b0010;
    bus.req_addr[15:8] = 8'h40;
    bus.req_wdata[15:8] = 8'h3C;
    service(2, 1'b1, 8'h77, 1'b0, 1'b0, w);
    check_grant("write_error", w, 1);
    bus.req = '0;
  endtask
  task automatic test_round_robin();
    int w;
    int order [9] = '{0, 1, 2, 3, 0, 1, 2, 0, 2};
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      if (i == 7) bus.req = 4'b0101;
      bus.req_wr = 4'($urandom);
      bus.req_addr = 32'($urandom);
      bus.req_wdata = 32'($urandom);
      service(int'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 1'b0, 1'b0, w);
      check_grant($sformatf("rr%0d", i), w, order[i]);
    end
    bus.req = '0;
  endtask
  task automatic clear_flag();
    bus.req = '0;
    bus.to_clr = 1'b1;
    cyc();
    bus.to_clr = 1'b0;
    mto = 1'b0;
    checks++;
    if (bus.to_flag !== 1'b0) begin
      failures++;
      $display("FAIL to_clr: to_flag=%b want 0", bus.to_flag);
    end
  endtask
  task automatic test_timeout();
    int w;
    bus.req = 4'b1000;
    bus.req_wr = 4'b0000;
    service(TO, 1'b0, 8'h5A, 1'b0, 1'b0, w);
    check_grant("timeout", w, 3);
    bus.req = '0;
    cyc();
    checks++;
    if (bus.to_flag !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky: to_flag=%b want 1", bus.to_flag);
    end
    clear_flag();
    bus.req = 4'b1000;
    service(TO - 1, 1'b0, 8'hC3, 1'b0, 1'b0, w);
    check_grant("last_cycle_ready", w, 3);
    bus.req = 4'b1000;
    service(TO, 1'b0, 8'h00, 1'b0, 1'b1, w);
    check_grant("timeout_vs_clr", w, 3);
    clear_flag();
  endtask
  task automatic test_field_stability();
    int w;
    bus.req = 4'b0100;
    bus.req_wr = 4'b0100;
    bus.req_addr[23:16] = 8'h9E;
    bus.req_wdata[23:16] = 8'h61;
    service(3, 1'b0, 8'h11, 1'b1, 1'b0, w);
    check_grant("field_stability", w, 2);
    bus.req = '0;
  endtask
  task automatic test_reset_mid_wait();
    int w;
    bus.req = 4'b0100;
    bus.req_wr = 4'b0000;
    bus.req_addr = 32'h11223344;
    bus.to_clr = 1'b0;
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check_zero("reset_mid_wait");
    mptr = 0;
    mrd = 8'h00;
    mto = 1'b0;
    cyc();
    reset = 1'b0;
    bus.req = 4'b1111;
    service(1, 1'b0, 8'h3D, 1'b0, 1'b0, w);
    check_grant("after_reset", w, 0);
    bus.req = '0;
  endtask
  task automatic test_random();
    int w;
    for (int i = 0; i < 40; i++) begin
      bus.req = 4'($urandom_range(1, 15));
      bus.req_wr = 4'($urandom);
      bus.req_addr = 32'($urandom);
      bus.req_wdata = 32'($urandom);
      service(int'($urandom_range(0, TO + 1)), 1'($urandom), 8'($urandom), 1'($urandom), 1'b0, w);
    end
    bus.req = '0;
  endtask
  initial begin
    bus.req = '0;
    bus.req_wr = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.to_clr = 1'b0;
    bus.m_rdata = 8'h00;
    bus.m_ready = 1'b0;
    bus.m_error = 1'b0;
    test_reset();
    test_single_read();
    test_write_error();
    test_round_robin();
    test_timeout();
    test_field_stability();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
